// File: rtl/popcnt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : popcnt_pkg                                                    |
// | Purpose  : Shared width helpers and output-stage state encoding for the  |
// |            population-count arbiter.                                     |
// | Contents : my_log2    - bits needed to hold a value (minimum 1)          |
// |            pos_width  - count result width for a DATA_W-bit vector       |
// |            id_width   - requester index width for N_REQ requesters       |
// |            out_state_t- EMPTY/FULL state of the result register          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package popcnt_pkg;

   // Number of bits needed to represent 'value'. A value of 0 still needs
   // one bit so that derived port widths never collapse to zero.
   function automatic int my_log2(input int value);
      int bits;
      int v;
      bits = 0;
      v    = value;
      for (int i = 0; i < 32; i++) begin
         if (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
         end
      end
      if (bits == 0) begin
         bits = 1;
      end
      return bits;
   endfunction

   // A full vector of data_w ones must fit, so size for the value data_w.
   function automatic int pos_width(input int data_w);
      return my_log2(data_w);
   endfunction

   // Largest index is n_req-1.
   function automatic int id_width(input int n_req);
      return my_log2(n_req - 1);
   endfunction

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage : popcnt_pkg
`default_nettype wire

// File: rtl/vector_summator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vector_summator                                               |
// | Purpose  : Combinational population count of one input vector.          |
// | Ports    : vec  in  DATA_W  vector to count                              |
// |            sum  out POS_W   number of set bits in vec                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vector_summator
   import popcnt_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int POS_W  = pos_width(DATA_W)
) (
   input  logic [DATA_W-1:0] vec,
   output logic [POS_W-1:0]  sum
);

   always_comb begin
      sum = '0;
      for (int i = 0; i < DATA_W; i++) begin
         sum = sum + POS_W'(vec[i]);
      end
   end

endmodule : vector_summator
`default_nettype wire

// File: rtl/popcnt_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : popcnt_arbiter                                                |
// | Purpose  : N_REQ requesters share one population-count datapath through |
// |            a round-robin arbiter; one registered result per cycle.       |
// | Ports    : clk        in  1             rising-edge clock                |
// |            rst        in  1             synchronous active-high reset    |
// |            req_valid  in  N_REQ         per-requester request valid      |
// |            req_data   in  N_REQ*DATA_W  slice k at [k*DATA_W +: DATA_W]  |
// |            req_ready  out N_REQ         one-hot accept (or all zero)     |
// |            out_valid  out 1             result register is occupied      |
// |            out_ready  in  1             downstream takes the result      |
// |            out_sum    out POS_W         set-bit count of granted slice   |
// |            out_id     out ID_W          index of the granted requester   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module popcnt_arbiter
   import popcnt_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int N_REQ  = 4,
   parameter int POS_W  = pos_width(DATA_W),
   parameter int ID_W   = id_width(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [POS_W-1:0]        out_sum,
   output logic [ID_W-1:0]         out_id
);

   out_state_t              state;
   out_state_t              state_next;
   logic [ID_W-1:0]         rr_ptr;
   logic [ID_W-1:0]         rr_ptr_next;
   logic [POS_W-1:0]        sum_next;
   logic [ID_W-1:0]         id_next;

   logic [2*N_REQ-1:0]      valid_dbl;
   logic [N_REQ-1:0]        valid_rot;
   logic                    found;
   logic [ID_W-1:0]         offset;
   logic [ID_W:0]           cand_ext;
   logic [ID_W-1:0]         cand;
   logic                    can_accept;
   logic                    transfer;
   logic [DATA_W-1:0]       granted_slice;
   logic [POS_W-1:0]        slice_sum;

   // ------------------------------------------------------------------
   // Round-robin candidate search: rotate the valid vector so that bit 0
   // corresponds to rr_ptr, pick the lowest set bit, then rotate the
   // resulting offset back into an absolute requester index.
   // ------------------------------------------------------------------
   assign valid_dbl = {req_valid, req_valid};
   assign valid_rot = N_REQ'(valid_dbl >> rr_ptr);

   always_comb begin
      found  = 1'b0;
      offset = '0;
      // Walk downward so the lowest set bit is the last one written.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (valid_rot[i]) begin
            found  = 1'b1;
            offset = ID_W'(i);
         end
      end
   end

   // rr_ptr and offset are both below N_REQ, so one conditional subtract
   // performs the modulo.
   assign cand_ext = {1'b0, rr_ptr} + {1'b0, offset};
   assign cand     = (cand_ext >= (ID_W+1)'(N_REQ))
                   ? ID_W'(cand_ext - (ID_W+1)'(N_REQ))
                   : cand_ext[ID_W-1:0];

   // The result register can take a new value when empty, or when its
   // current value leaves this cycle.
   assign can_accept = (state == ST_EMPTY) || out_ready;
   assign transfer   = found && can_accept && !rst;

   always_comb begin
      req_ready = '0;
      for (int k = 0; k < N_REQ; k++) begin
         req_ready[k] = transfer && (cand == ID_W'(k));
      end
   end

   // ------------------------------------------------------------------
   // Granted-slice mux feeding the shared count datapath.
   // ------------------------------------------------------------------
   always_comb begin
      granted_slice = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (cand == ID_W'(k)) begin
            granted_slice = req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   vector_summator #(
      .DATA_W (DATA_W),
      .POS_W  (POS_W)
   ) u_summator (
      .vec (granted_slice),
      .sum (slice_sum)
   );

   // ------------------------------------------------------------------
   // Output stage: next-state and register-next logic.
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state;
      sum_next    = out_sum;
      id_next     = out_id;
      rr_ptr_next = rr_ptr;

      if (transfer) begin
         sum_next    = slice_sum;
         id_next     = cand;
         rr_ptr_next = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + ID_W'(1);
      end

      case (state)
         ST_EMPTY: begin
            if (transfer) begin
               state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            // A transfer while full means drain and refill on the same edge.
            if (!transfer && out_ready) begin
               state_next = ST_EMPTY;
            end
         end
         default: begin
            state_next = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_EMPTY;
         out_sum <= '0;
         out_id  <= '0;
         rr_ptr  <= '0;
      end else begin
         state   <= state_next;
         out_sum <= sum_next;
         out_id  <= id_next;
         rr_ptr  <= rr_ptr_next;
      end
   end

   assign out_valid = (state == ST_FULL);

endmodule : popcnt_arbiter
`default_nettype wire

// File: doc/popcnt_arbiter.md
POPCNT_ARBITER -- requirements
Module: popcnt_arbiter

Interface
REQ-001 Parameter DATA_W, default 10, width of each requester's input vector.
REQ-002 Parameter N_REQ, default 4, number of requesters sharing the population-count datapath; legal range 2..16.
REQ-003 Parameter POS_W, default my_log2(DATA_W) (number of bits needed to hold DATA_W), width of a count result.
REQ-004 Parameter ID_W, default my_log2(N_REQ-1), width of a requester index.
REQ-005 Ports, one clock; reset is synchronous and active-high:
  clk        in   1               rising-edge clock
  rst        in   1               synchronous active-high reset
  req_valid  in   N_REQ           per-requester request valid
  req_data   in   N_REQ*DATA_W    flattened vectors; requester k occupies bits [k*DATA_W +: DATA_W]
  req_ready  out  N_REQ           per-requester accept; at most one bit high per cycle
  out_valid  out  1               result register holds a valid result
  out_ready  in   1               downstream accepts result
  out_sum    out  POS_W           number of set bits in the granted vector
  out_id     out  ID_W            index of the requester that produced out_sum

Function
REQ-006 Arbitration is round-robin: the search starts at rr_ptr and proceeds upward modulo N_REQ; the first k with req_valid[k]=1 is the candidate.
REQ-007 can_accept = !out_valid || out_ready; req_ready[k] = can_accept && (k is the candidate); req_ready is combinational from req_valid, rr_ptr, out_valid and out_ready.
REQ-008 A transfer occurs on a cycle where req_valid[k] && req_ready[k]; at that edge out_sum <= popcount(slice k), out_id <= k, out_valid <= 1, and rr_ptr <= (k+1) mod N_REQ.
REQ-009 Latency is one cycle: a vector accepted at edge n has its result visible on out_sum/out_id after edge n.
REQ-010 Output is a two-state machine: EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on a transfer. FULL->EMPTY on out_ready with no transfer. FULL->FULL on a transfer, or while out_ready=0.
REQ-011 While FULL with out_ready=0, out_sum, out_id, out_valid and rr_ptr hold their values, and all req_ready bits are 0.
REQ-012 When FULL, out_ready=1 and a candidate exists in the same cycle, drain and accept occur at the same edge; out_valid stays 1, giving throughput of one result per cycle.
REQ-013 With no req_valid bit set, rr_ptr holds.
REQ-014 Counting is unsigned. POS_W is sized so that a full vector (DATA_W ones) never overflows; out_sum = DATA_W for an all-ones vector.
REQ-015 req_data of non-granted requesters has no effect on any state.

Reset
REQ-016 While rst=1 at a rising edge: out_valid<=0, out_sum<=0, out_id<=0, rr_ptr<=0; any pending result is discarded.
REQ-017 While rst=1, all req_ready bits are 0 and no transfer occurs, regardless of req_valid.
REQ-018 The first cycle after reset deasserts arbitrates from index 0.

Structure
REQ-019 Shared package popcnt_pkg holds the my_log2 width function and the derived-width helpers used for POS_W and ID_W.
REQ-020 The count datapath is a single instance of the existing vector_summator sub-module, parameterised with DATA_W and POS_W and fed by a granted-slice mux.
REQ-021 The round-robin candidate search is implemented in-module as a rotate/priority-encode; it is not a separate module.

Verification (DATA_W=10, N_REQ=4)
REQ-022 Reset: hold rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, out_valid=0, out_sum=0, out_id=0.
REQ-023 Single request: req_valid=4'b0010, slice1=10'b1011001110, out_ready=1 -> req_ready=4'b0010; next cycle out_valid=1, out_sum=6, out_id=1.
REQ-024 Fairness: all valid continuously with slices 0x000, 0x3FF, 0x001, 0x155 and out_ready=1 -> grant order 0,1,2,3,0 and sums 0,10,1,5,0 on consecutive cycles.
REQ-025 Backpressure: FULL with out_ready=0 for 5 cycles and req_valid=4'b0100 -> req_ready=0 and outputs stable. Then raise out_ready -> drain and accept on the same edge; out_valid stays 1 and out_id=2.
REQ-026 Wrap: after a grant to 2, req_valid=4'b1001 -> grant to 3, then to 0.
REQ-027 Reset mid-operation: out_valid=1, rr_ptr=3, pulse rst -> out_valid=0. Then req_valid=4'b1001 -> grant to 0 first.
